// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT address-generation blocks.
//   LOG2N_MAX_DEFAULT : default maximum log2 transform length
//   K_W               : width of the run-time length exponent (cfg_log2n)
//   MODE_NAT/MODE_REV : address ordering select values
//   fft_state_t       : sequencer FSM state encoding
//   clamp_log2n()     : folds an out-of-range exponent into 1..max_log2n
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam int LOG2N_MAX_DEFAULT = 10;
  localparam int K_W               = 4;

  localparam logic MODE_NAT = 1'b0;
  localparam logic MODE_REV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fft_state_t;

  // A zero exponent would mean a one-point frame, which the RAM ping-pong
  // scheme cannot use, so it is treated as the smallest real frame (N=2).
  function automatic logic [K_W-1:0] clamp_log2n(input logic [K_W-1:0] cfg,
                                                 input int max_log2n);
    logic [K_W-1:0] k;
    if (cfg == '0) begin
      k = K_W'(1);
    end else if (int'(cfg) > max_log2n) begin
      k = K_W'(max_log2n);
    end else begin
      k = cfg;
    end
    return k;
  endfunction

endpackage

// File: rtl/bit_reverse_var.sv
// ---------------------------------------------------------------------------
// bit_reverse_var
// Combinational variable-width bit reversal.
//   value    in   W      input word
//   k        in   K_W    number of low bits taking part in the reversal
//   reversed out  W      value[k-1:0] reversed over exactly k bits,
//                        all bits at and above position k are zero
// ---------------------------------------------------------------------------
module bit_reverse_var
  import fft_pkg::*;
#(
  parameter int W = LOG2N_MAX_DEFAULT
) (
  input  logic [W-1:0]   value,
  input  logic [K_W-1:0] k,
  output logic [W-1:0]   reversed
);

  logic [W-1:0] full_rev;

  // Reversing the whole word and then shifting right by (W-k) both discards
  // the bits above k and lands the reversed field at bit 0.
  always_comb begin
    full_rev = '0;
    for (int i = 0; i < W; i++) begin
      full_rev[i] = value[W-1-i];
    end
    if (int'(k) >= W) begin
      reversed = full_rev;
    end else begin
      reversed = full_rev >> (W - int'(k));
    end
  end

endmodule

// File: rtl/bitrev_addr_gen.sv
// ---------------------------------------------------------------------------
// bitrev_addr_gen
// Run-time sized address sequencer for the FFT ping-pong sample memory.
// Each frame emits N = 2**k addresses (k = clamped cfg_log2n) in natural or
// bit-reversed order over a valid/ready stream, then pulses done and flips
// the ping-pong bank select.
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous active-high reset
//   start      in   1          frame request, honoured only when idle
//   cfg_log2n  in   4          frame length exponent, sampled on start
//   cfg_mode   in   1          0 natural, 1 bit-reversed, sampled on start
//   busy       out  1          frame in progress
//   addr       out  LOG2N_MAX  current address (zero above bit k-1)
//   addr_idx   out  CNT_W      natural index of current address
//   addr_valid out  1          addr/addr_idx/addr_last valid
//   addr_ready in   1          consumer takes the beat on valid&&ready
//   addr_last  out  1          final beat of the frame
//   done       out  1          one-cycle pulse after the final beat
//   bank_sel   out  1          ping-pong bank, toggles with done
// ---------------------------------------------------------------------------
module bitrev_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N_MAX = LOG2N_MAX_DEFAULT,
  parameter int CNT_W     = LOG2N_MAX + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [K_W-1:0]       cfg_log2n,
  input  logic                 cfg_mode,
  output logic                 busy,
  output logic [LOG2N_MAX-1:0] addr,
  output logic [CNT_W-1:0]     addr_idx,
  output logic                 addr_valid,
  input  logic                 addr_ready,
  output logic                 addr_last,
  output logic                 done,
  output logic                 bank_sel
);

  fft_state_t           state_q, state_next;
  logic [K_W-1:0]       k_q, k_next;
  logic                 mode_q, mode_next;
  logic [CNT_W-1:0]     cnt_q, cnt_next;
  logic [CNT_W-1:0]     last_idx;
  logic                 last_q, last_next;
  logic                 bank_q, bank_next;
  logic [LOG2N_MAX-1:0] addr_q, addr_next;
  logic [LOG2N_MAX-1:0] rev_addr;

  assign last_idx = (CNT_W'(1) << k_q) - CNT_W'(1);

  always_comb begin
    state_next = state_q;
    k_next     = k_q;
    mode_next  = mode_q;
    cnt_next   = cnt_q;
    last_next  = last_q;
    bank_next  = bank_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_next     = clamp_log2n(cfg_log2n, LOG2N_MAX);
          mode_next  = cfg_mode;
          cnt_next   = '0;
          // k is at least 1, so index 0 is never the final beat.
          last_next  = 1'b0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (addr_ready) begin
          if (cnt_q == last_idx) begin
            // Counter stays at N-1 rather than wrapping; the bank flips on
            // entry to DONE so the new value is visible alongside done.
            bank_next  = ~bank_q;
            state_next = ST_DONE;
          end else begin
            cnt_next  = cnt_q + CNT_W'(1);
            last_next = ((cnt_q + CNT_W'(1)) == last_idx);
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // The address is looked up from the next counter value so that it can be
  // registered together with the counter and never depends on addr_ready
  // within the same cycle.
  bit_reverse_var #(
    .W (LOG2N_MAX)
  ) u_rev (
    .value    (cnt_next[LOG2N_MAX-1:0]),
    .k        (k_next),
    .reversed (rev_addr)
  );

  assign addr_next = (mode_next == MODE_REV) ? rev_addr : cnt_next[LOG2N_MAX-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      mode_q  <= MODE_NAT;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      bank_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_next;
      k_q     <= k_next;
      mode_q  <= mode_next;
      cnt_q   <= cnt_next;
      last_q  <= last_next;
      bank_q  <= bank_next;
      addr_q  <= addr_next;
    end
  end

  assign addr_valid = (state_q == ST_RUN);
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign addr       = addr_q;
  assign addr_idx   = cnt_q;
  assign addr_last  = last_q;
  assign bank_sel   = bank_q;

endmodule

// File: tb/tb_bitrev_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_bitrev_addr_gen
// Self-checking bench for bitrev_addr_gen (LOG2N_MAX = 10). Expected address
// sequences come from an arithmetic reference model of natural and
// bit-reversed ordering; inputs are driven and outputs sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_bitrev_addr_gen;

  localparam int LMAX = 10;
  localparam int CW   = 11;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [3:0]      cfg_log2n;
  logic            cfg_mode;
  logic            busy;
  logic [LMAX-1:0] addr;
  logic [CW-1:0]   addr_idx;
  logic            addr_valid;
  logic            addr_ready;
  logic            addr_last;
  logic            done;
  logic            bank_sel;

  bitrev_addr_gen #(
    .LOG2N_MAX (LMAX),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_log2n  (cfg_log2n),
    .cfg_mode   (cfg_mode),
    .busy       (busy),
    .addr       (addr),
    .addr_idx   (addr_idx),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr_last  (addr_last),
    .done       (done),
    .bank_sel   (bank_sel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic bank_model = 1'b0;

  // Results captured by run_frame for the calling test to judge.
  logic [LMAX-1:0] obs_addr[$];
  logic [CW-1:0]   obs_idx[$];
  logic            obs_last[$];
  int   entry_cyc, first_cyc, last_beat_cyc, done_cyc, stab_err, busy_err;
  bit   done_seen;
  logic done_bank, done_busy;

  function automatic int eff_k(input int cfg);
    if (cfg < 1) return 1;
    if (cfg > LMAX) return LMAX;
    return cfg;
  endfunction

  // Reference ordering: natural index, or the index read backwards in k bits.
  function automatic int model_addr(input int i, input int k, input logic mode);
    int r, x;
    if (mode == 1'b0) return i;
    r = 0;
    x = i;
    for (int b = 0; b < k; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    addr_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bank_model = 1'b0;
  endtask

  // Drives one frame request and records every accepted beat. During RUN the
  // cfg inputs are scrambled and start may be held to prove they are ignored.
  // ready_kind: 0 always ready, 1 alternating 1010..., 2 random.
  task automatic run_frame(input logic [3:0] log2n, input logic mode,
                           input int ready_kind, input bit hold_start);
    int              phase;
    bit              have_prev, p_acc, rdy;
    logic [LMAX-1:0] p_addr;
    logic [CW-1:0]   p_idx;
    logic            p_last;
    phase = 0; have_prev = 0; p_acc = 0;
    p_addr = '0; p_idx = '0; p_last = 1'b0;
    obs_addr.delete(); obs_idx.delete(); obs_last.delete();
    done_seen = 0; first_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
    stab_err = 0; busy_err = 0; done_bank = 1'b0; done_busy = 1'b0;
    entry_cyc = cyc;
    start = 1'b1;
    cfg_log2n = log2n;
    cfg_mode = mode;
    addr_ready = 1'b0;
    for (int c = 0; c < 4000 && !done_seen; c++) begin
      @(negedge clk);
      if (done) begin
        done_seen = 1;
        done_cyc = cyc;
        done_bank = bank_sel;
        done_busy = busy;
        start = 1'b0;
        addr_ready = 1'b0;
      end else if (addr_valid) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          start = hold_start;
        end
        cfg_log2n = 4'($urandom_range(0, 15));
        cfg_mode = 1'($urandom_range(0, 1));
        if (!busy) busy_err++;
        if (have_prev && !p_acc &&
            (addr !== p_addr || addr_idx !== p_idx || addr_last !== p_last))
          stab_err++;
        case (ready_kind)
          0:       rdy = 1'b1;
          1:       rdy = (phase % 2 == 0);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        phase++;
        addr_ready = rdy;
        if (rdy) begin
          obs_addr.push_back(addr);
          obs_idx.push_back(addr_idx);
          obs_last.push_back(addr_last);
          last_beat_cyc = cyc;
        end
        have_prev = 1;
        p_acc = rdy;
        p_addr = addr;
        p_idx = addr_idx;
        p_last = addr_last;
      end
    end
    start = 1'b0;
    addr_ready = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    @(negedge clk);
    rst = 1'b1; start = 1'b1; cfg_log2n = 4'd3; cfg_mode = 1'b1; addr_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (addr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got %b want 0", addr_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (addr !== '0) begin n_fail++; $display("[TB] FAIL reset_addr got %0d want 0", addr); end
    n_checks++; if (addr_idx !== '0) begin n_fail++; $display("[TB] FAIL reset_idx got %0d want 0", addr_idx); end
    n_checks++; if (addr_last !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_last got %b want 0", addr_last); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %b want 0", done); end
    n_checks++; if (bank_sel !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_bank got %b want 0", bank_sel); end
    rst = 1'b0; start = 1'b0; addr_ready = 1'b0;
    bank_model = 1'b0;
  endtask

  task automatic test_rev_basic();
    int n;
    $display("[TB] test_rev_basic");
    run_frame(4'd3, 1'b1, 0, 1'b0);
    n = 8;
    n_checks++; if (obs_addr.size() != n) begin n_fail++; $display("[TB] FAIL rev8_count got %0d want %0d", obs_addr.size(), n); end
    for (int i = 0; i < obs_addr.size() && i < n; i++) begin
      n_checks++;
      if (obs_addr[i] !== LMAX'(model_addr(i, 3, 1'b1)) || obs_idx[i] !== CW'(i) || obs_last[i] !== (i == n - 1)) begin
        n_fail++;
        $display("[TB] FAIL rev8_beat%0d got addr=%0d idx=%0d last=%b want addr=%0d idx=%0d last=%b",
                 i, obs_addr[i], obs_idx[i], obs_last[i], model_addr(i, 3, 1'b1), i, (i == n - 1));
      end
    end
    n_checks++; if (first_cyc - entry_cyc != 1) begin n_fail++; $display("[TB] FAIL rev8_latency got %0d want 1", first_cyc - entry_cyc); end
    n_checks++; if (!done_seen || done_cyc != last_beat_cyc + 1) begin n_fail++; $display("[TB] FAIL rev8_done_timing got %0d want %0d", done_cyc, last_beat_cyc + 1); end
    bank_model = ~bank_model;
    n_checks++; if (done_bank !== bank_model) begin n_fail++; $display("[TB] FAIL rev8_bank got %b want %b", done_bank, bank_model); end
    n_checks++; if (done_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rev8_busy_at_done got %b want 0", done_busy); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL rev8_done_width got %b want 0", done); end
  endtask

  task automatic test_nat_backpressure();
    int n;
    $display("[TB] test_nat_backpressure");
    run_frame(4'd3, 1'b0, 1, 1'b0);
    n = 8;
    n_checks++; if (obs_addr.size() != n) begin n_fail++; $display("[TB] FAIL nat8_count got %0d want %0d", obs_addr.size(), n); end
    for (int i = 0; i < obs_addr.size() && i < n; i++) begin
      n_checks++;
      if (obs_addr[i] !== LMAX'(i) || obs_idx[i] !== CW'(i) || obs_last[i] !== (i == n - 1)) begin
        n_fail++;
        $display("[TB] FAIL nat8_beat%0d got addr=%0d idx=%0d last=%b want addr=%0d idx=%0d last=%b",
                 i, obs_addr[i], obs_idx[i], obs_last[i], i, i, (i == n - 1));
      end
    end
    n_checks++; if (stab_err != 0) begin n_fail++; $display("[TB] FAIL nat8_hold_stable got %0d changes want 0", stab_err); end
    n_checks++; if (busy_err != 0) begin n_fail++; $display("[TB] FAIL nat8_busy got %0d low cycles want 0", busy_err); end
    bank_model = ~bank_model;
    n_checks++; if (!done_seen || done_bank !== bank_model) begin n_fail++; $display("[TB] FAIL nat8_bank got %b want %b", done_bank, bank_model); end
  endtask

  task automatic test_rev16();
    int n;
    $display("[TB] test_rev16");
    run_frame(4'd4, 1'b1, 2, 1'b0);
    n = 16;
    n_checks++; if (obs_addr.size() != n) begin n_fail++; $display("[TB] FAIL rev16_count got %0d want %0d", obs_addr.size(), n); end
    for (int i = 0; i < obs_addr.size() && i < n; i++) begin
      n_checks++;
      if (obs_addr[i] !== LMAX'(model_addr(i, 4, 1'b1)) || obs_idx[i] !== CW'(i) || obs_last[i] !== (i == n - 1)) begin
        n_fail++;
        $display("[TB] FAIL rev16_beat%0d got addr=%0d idx=%0d last=%b want addr=%0d idx=%0d last=%b",
                 i, obs_addr[i], obs_idx[i], obs_last[i], model_addr(i, 4, 1'b1), i, (i == n - 1));
      end
    end
    n_checks++; if (stab_err != 0) begin n_fail++; $display("[TB] FAIL rev16_hold_stable got %0d changes want 0", stab_err); end
    bank_model = ~bank_model;
    n_checks++; if (!done_seen || done_bank !== bank_model) begin n_fail++; $display("[TB] FAIL rev16_bank got %b want %b", done_bank, bank_model); end
  endtask

  task automatic test_range();
    int n;
    $display("[TB] test_range");
    run_frame(4'd0, 1'b1, 0, 1'b0);
    n_checks++; if (obs_addr.size() != 2) begin n_fail++; $display("[TB] FAIL cfg0_count got %0d want 2", obs_addr.size()); end
    for (int i = 0; i < obs_addr.size() && i < 2; i++) begin
      n_checks++;
      if (obs_addr[i] !== LMAX'(i) || obs_last[i] !== (i == 1)) begin
        n_fail++;
        $display("[TB] FAIL cfg0_beat%0d got addr=%0d last=%b want addr=%0d last=%b", i, obs_addr[i], obs_last[i], i, (i == 1));
      end
    end
    bank_model = ~bank_model;
    run_frame(4'd15, 1'b0, 0, 1'b1);
    n = 1 << eff_k(15);
    n_checks++; if (obs_addr.size() != n) begin n_fail++; $display("[TB] FAIL cfg15_count got %0d want %0d", obs_addr.size(), n); end
    for (int i = 0; i < obs_addr.size() && i < n; i++) begin
      n_checks++;
      if (obs_addr[i] !== LMAX'(i) || obs_idx[i] !== CW'(i) || obs_last[i] !== (i == n - 1)) begin
        n_fail++;
        $display("[TB] FAIL cfg15_beat%0d got addr=%0d idx=%0d last=%b want addr=%0d idx=%0d last=%b",
                 i, obs_addr[i], obs_idx[i], obs_last[i], i, i, (i == n - 1));
      end
    end
    bank_model = ~bank_model;
    n_checks++; if (!done_seen || done_bank !== bank_model) begin n_fail++; $display("[TB] FAIL cfg15_bank got %b want %b", done_bank, bank_model); end
    repeat (3) @(negedge clk);
    n_checks++; if (addr_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL cfg15_idle_after got valid=%b busy=%b want 0 0", addr_valid, busy); end
  endtask

  task automatic test_midframe_reset();
    bit found;
    $display("[TB] test_midframe_reset");
    do_reset();
    found = 0;
    start = 1'b1; cfg_log2n = 4'd3; cfg_mode = 1'b0; addr_ready = 1'b1;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (addr_valid && addr_idx == CW'(3)) found = 1;
    end
    n_checks++; if (!found) begin n_fail++; $display("[TB] FAIL midrst_reach_beat3 got 0 want 1"); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (addr_valid !== 1'b0 || busy !== 1'b0 || addr !== '0 || addr_idx !== '0 ||
        addr_last !== 1'b0 || done !== 1'b0 || bank_sel !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midrst_outputs got v=%b b=%b a=%0d i=%0d l=%b d=%b bank=%b want all 0",
               addr_valid, busy, addr, addr_idx, addr_last, done, bank_sel);
    end
    rst = 1'b0;
    addr_ready = 1'b0;
    bank_model = 1'b0;
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || bank_sel !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_no_done got done=%b bank=%b want 0 0", done, bank_sel); end
    run_frame(4'd3, 1'b0, 0, 1'b0);
    n_checks++; if (obs_idx.size() != 8) begin n_fail++; $display("[TB] FAIL midrst_restart_count got %0d want 8", obs_idx.size()); end
    n_checks++; if (obs_idx.size() == 0 || obs_idx[0] !== '0) begin n_fail++; $display("[TB] FAIL midrst_restart_idx0 got %0d want 0", (obs_idx.size() == 0) ? -1 : int'(obs_idx[0])); end
    bank_model = ~bank_model;
    n_checks++; if (!done_seen || done_bank !== bank_model) begin n_fail++; $display("[TB] FAIL midrst_bank got %b want %b", done_bank, bank_model); end
  endtask

  task automatic test_back_to_back();
    int   d1;
    logic b1;
    int   c1;
    $display("[TB] test_back_to_back");
    do_reset();
    run_frame(4'd3, 1'b1, 0, 1'b1);
    d1 = done_cyc;
    b1 = done_bank;
    c1 = obs_addr.size();
    run_frame(4'd3, 1'b0, 0, 1'b1);
    n_checks++; if (c1 != 8 || obs_addr.size() != 8) begin n_fail++; $display("[TB] FAIL b2b_counts got %0d,%0d want 8,8", c1, obs_addr.size()); end
    n_checks++; if (first_cyc != d1 + 2) begin n_fail++; $display("[TB] FAIL b2b_gap got %0d want %0d", first_cyc - d1, 2); end
    n_checks++; if (b1 !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_bank1 got %b want 1", b1); end
    n_checks++; if (!done_seen || done_bank !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_bank2 got %b want 0", done_bank); end
    bank_model = 1'b0;
  endtask

  task automatic test_random();
    int   lg, k, n;
    logic md;
    $display("[TB] test_random");
    for (int f = 0; f < 6; f++) begin
      lg = $urandom_range(0, 6);
      md = 1'($urandom_range(0, 1));
      k = eff_k(lg);
      n = 1 << k;
      run_frame(4'(lg), md, 2, 1'($urandom_range(0, 1)));
      n_checks++; if (obs_addr.size() != n) begin n_fail++; $display("[TB] FAIL rnd%0d_count got %0d want %0d", f, obs_addr.size(), n); end
      for (int i = 0; i < obs_addr.size() && i < n; i++) begin
        n_checks++;
        if (obs_addr[i] !== LMAX'(model_addr(i, k, md)) || obs_idx[i] !== CW'(i) || obs_last[i] !== (i == n - 1)) begin
          n_fail++;
          $display("[TB] FAIL rnd%0d_beat%0d got addr=%0d idx=%0d last=%b want addr=%0d idx=%0d last=%b",
                   f, i, obs_addr[i], obs_idx[i], obs_last[i], model_addr(i, k, md), i, (i == n - 1));
        end
      end
      n_checks++; if (stab_err != 0) begin n_fail++; $display("[TB] FAIL rnd%0d_hold_stable got %0d want 0", f, stab_err); end
      bank_model = ~bank_model;
      n_checks++; if (!done_seen || done_bank !== bank_model) begin n_fail++; $display("[TB] FAIL rnd%0d_bank got %b want %b", f, done_bank, bank_model); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg_log2n = 4'd0;
    cfg_mode = 1'b0;
    addr_ready = 1'b0;
    test_reset();
    test_rev_basic();
    test_nat_backpressure();
    test_rev16();
    test_range();
    test_midframe_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
